// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared types and helpers for the note/bar sequencer.
//   state_e  : sequencer FSM states (IDLE, RUN)
//   BCD_ONE  : first note of a bar, two-digit BCD
//   bcd_inc  : two-digit BCD increment (units 9 carries into tens)
//   to_bcd   : binary 0..99 to two-digit BCD, used for elaboration constants
// -----------------------------------------------------------------------------
package seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [7:0] BCD_ONE = 8'h01;

  function automatic logic [7:0] bcd_inc(input logic [7:0] value);
    logic [3:0] units;
    logic [3:0] tens;
    units = value[3:0];
    tens  = value[7:4];
    if (units >= 4'd9) begin
      units = 4'd0;
      tens  = (tens >= 4'd9) ? 4'd0 : tens + 4'd1;
    end else begin
      units = units + 4'd1;
    end
    return {tens, units};
  endfunction

  function automatic logic [7:0] to_bcd(input int unsigned value);
    return {4'(value / 10), 4'(value % 10)};
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// -----------------------------------------------------------------------------
// key_debouncer
// Synchronizes one raw active-low push-button and accepts a new level only
// after DEBOUNCE_CYCLES consecutive cycles of it. A press is a 1->0 change of
// the accepted level, issued as a one-cycle pulse in the same cycle the
// accepted level falls (raw edge to pulse: 2 + DEBOUNCE_CYCLES cycles).
//   iCLK    : clock
//   iRST    : asynchronous active-low reset
//   iKEY_n  : raw key, asynchronous to iCLK
//   oLevel  : accepted (debounced) level
//   oPress  : single-cycle press pulse
// The accepted level resets to 0, so a key already held low when reset is
// released yields no press until it is released and pressed again.
// -----------------------------------------------------------------------------
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iKEY_n,
  output logic oLevel,
  output logic oPress
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;

  // Count consecutive cycles in which the synchronized level differs from the
  // accepted one; any return to the accepted level restarts the count.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
        press_d = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], iKEY_n};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign oLevel = level_q;
  assign oPress = press_q;

endmodule

// File: rtl/note_bar_sequencer.sv
// -----------------------------------------------------------------------------
// note_bar_sequencer
// Producer side of the seven-segment status path: debounces the save/play and
// mode keys and runs a tempo-driven BCD note / binary bar counter.
//   iCLK         : clock
//   iRST         : asynchronous active-low reset
//   iKEY_SAVE_n  : raw save/play key, active-low
//   iKEY_MODE_n  : raw mode key, active-low
//   iRUN         : 0 pauses the tempo counter while running
//   oNote        : two BCD digits, 00 = no note
//   oBar         : bar index 0..MAX_BAR
//   oSave_n      : one-cycle active-low save/play strobe
//   oMode        : 0 = save mode, 1 = play mode
//   oBusy        : 1 while in RUN
// Build option: define SEQ_LOOP_EN to loop back to bar 0 after the last note
// of bar MAX_BAR; otherwise the sequencer stops in IDLE holding NOTES_PER_BAR
// and MAX_BAR.
// -----------------------------------------------------------------------------
module note_bar_sequencer
  import seq_pkg::*;
#(
  parameter int TICKS_PER_NOTE  = 12500000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NOTES_PER_BAR   = 16,
  parameter int MAX_BAR         = 8
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iKEY_SAVE_n,
  input  logic       iKEY_MODE_n,
  input  logic       iRUN,
  output logic [7:0] oNote,
  output logic [3:0] oBar,
  output logic       oSave_n,
  output logic       oMode,
  output logic       oBusy
);

  localparam int              TW         = $clog2(TICKS_PER_NOTE);
  localparam logic [TW-1:0]   TICK_LAST  = TW'(TICKS_PER_NOTE - 1);
  localparam logic [7:0]      LAST_NOTE  = to_bcd(NOTES_PER_BAR);
  localparam logic [3:0]      LAST_BAR   = 4'(MAX_BAR);

  logic save_press, mode_press;
  logic save_level, mode_level;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_save_key (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iKEY_n (iKEY_SAVE_n),
    .oLevel (save_level),
    .oPress (save_press)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_key (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iKEY_n (iKEY_MODE_n),
    .oLevel (mode_level),
    .oPress (mode_press)
  );

  // Accepted key levels are not consumed here; kept visible for probing.
  logic unused_levels;
  assign unused_levels = save_level ^ mode_level;

  state_e        state_q;
  logic [TW-1:0] tick_q;
  logic [7:0]    note_q;
  logic [3:0]    bar_q;
  logic          save_n_q;
  logic          mode_q;

  // Save decisions read mode_q, i.e. the mode before a same-cycle toggle.
  // A save press takes priority over a note advance in the same cycle.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      note_q   <= 8'h00;
      bar_q    <= 4'd0;
      save_n_q <= 1'b1;
      mode_q   <= 1'b0;
    end else begin
      save_n_q <= ~save_press;
      mode_q   <= mode_q ^ mode_press;
      case (state_q)
        IDLE: begin
          if (save_press && mode_q) begin
            state_q <= RUN;
            note_q  <= BCD_ONE;
            bar_q   <= 4'd0;
            tick_q  <= '0;
          end
        end
        RUN: begin
          if (save_press) begin
            if (mode_q) begin
              note_q <= BCD_ONE;
              bar_q  <= 4'd0;
              tick_q <= '0;
            end else begin
              state_q <= IDLE;
            end
          end else if (iRUN) begin
            if (tick_q == TICK_LAST) begin
              tick_q <= '0;
              if (note_q == LAST_NOTE) begin
                if (bar_q == LAST_BAR) begin
`ifdef SEQ_LOOP_EN
                  note_q <= BCD_ONE;
                  bar_q  <= 4'd0;
`else
                  state_q <= IDLE;
`endif
                end else begin
                  note_q <= BCD_ONE;
                  bar_q  <= bar_q + 4'd1;
                end
              end else begin
                note_q <= bcd_inc(note_q);
              end
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oNote   = note_q;
  assign oBar    = bar_q;
  assign oSave_n = save_n_q;
  assign oMode   = mode_q;
  assign oBusy   = (state_q == RUN);

endmodule

// File: doc/note_bar_sequencer.md
Name: note_bar_sequencer

Overview:
- Producer side of the seven-segment status path: generates the BCD note index, bar index, active-low save strobe and mode bit that the display decoder consumes.
- Debounces the two push-buttons, the save/play key and the mode key.
- Runs a tempo-driven note/bar counter.
- Sits between the board KEY inputs and the seven-segment decoder in the SDRAM_Camera top level.

Parameters:
- TICKS_PER_NOTE, 12500000: iCLK cycles per note step (4 notes/s at 50 MHz); legal range ≥2.
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before a key level is accepted; legal range ≥1.
- NOTES_PER_BAR, 16: notes per bar; legal range 1..99 (BCD).
- MAX_BAR, 8: highest bar index; legal range 0..9.

Ports:
- iCLK  in  1  system clock
- iRST  in  1  reset; asynchronous, active-low
- iKEY_SAVE_n  in  1  raw save/play push-button, active-low, asynchronous to iCLK
- iKEY_MODE_n  in  1  raw mode push-button, active-low, asynchronous to iCLK
- iRUN  in  1  level; 0 pauses the tempo counter in RUN
- oNote  out  8  two BCD digits, [7:4] tens, [3:0] units; 00 means no note (decoder blanks it)
- oBar  out  4  bar index, binary 0..MAX_BAR
- oSave_n  out  1  active-low save/play strobe, exactly one iCLK cycle wide
- oMode  out  1  0 = save mode, 1 = play mode
- oBusy  out  1  1 while the FSM is in RUN

Behaviour:
- Reset values: oNote=8'h00, oBar=0, oSave_n=1, oMode=0, oBusy=0. FSM=IDLE; tick, debounce and synchronizer registers cleared. Reset asserted mid-sequence aborts immediately to these values.
- Key path, per key:
  - 2-FF synchronizer (reset value 1).
  - Debounce counter: the accepted level changes only after DEBOUNCE_CYCLES consecutive cycles of the new synchronized level. Any bounce restarts the count.
  - A press event is a 1→0 transition of the accepted level. It is a single-cycle pulse.
  - Latency from a stable raw edge to the press pulse: 2 + DEBOUNCE_CYCLES cycles.
- Mode press: oMode toggles on the cycle after the pulse.
- Save press:
  - oSave_n=0 for exactly one cycle, the cycle after the pulse.
  - The action uses the registered oMode value, i.e. the value before any same-cycle toggle.
  - Save and mode pressed in the same cycle: save acts on the old mode and oMode toggles. Both take effect together.
- FSM states: IDLE, RUN.
  - IDLE: counters hold. A save press with oMode=1 → RUN, oNote=8'h01, oBar=0, tick=0. A save press with oMode=0 stays IDLE and keeps the values.
  - RUN:
    - If iRUN=1, the tick counter increments each cycle.
    - When tick==TICKS_PER_NOTE-1: tick←0 and the note advances.
    - If iRUN=0, tick holds and the note is frozen.
  - RUN, save press with oMode=0: → IDLE, holding current oNote/oBar (freeze for save).
  - RUN, save press with oMode=1: restart, oNote=01, oBar=0, tick=0, stays RUN.
  - A save press in the same cycle as a note advance wins; the advance is discarded.
- Note advance:
  - oNote is a BCD increment. Units 9→0 carries into the tens.
  - When oNote==NOTES_PER_BAR (in BCD), oNote←01 and oBar increments.
  - oBar==MAX_BAR at bar wrap: behaviour is set by SEQ_LOOP_EN.
- oNote never holds a non-BCD digit and never exceeds NOTES_PER_BAR.

Optional Feature:
- Macro: SEQ_LOOP_EN.
- Defined: after the last note of bar MAX_BAR, oBar←0, oNote←01, and the FSM stays RUN (endless loop).
- Undefined: at that point the FSM goes to IDLE, oNote and oBar hold their final values (NOTES_PER_BAR, MAX_BAR), and oBusy drops the same cycle.

Decomposition:
- Package seq_pkg:
  - State typedef {IDLE, RUN}.
  - BCD_ONE constant = 8'h01.
  - BCD increment function for an 8-bit two-digit value.
- Sub-module key_debouncer (parameter DEBOUNCE_CYCLES):
  - Ports: iCLK, iRST, raw key in; accepted level out; press pulse out.
  - Instantiated twice in note_bar_sequencer.

Test Plan:
Bench parameters: TICKS_PER_NOTE=4, DEBOUNCE_CYCLES=3, NOTES_PER_BAR=12, MAX_BAR=2.
- Reset with both keys held low → all outputs at reset values. No press pulse until a key is released and pressed again.
- Mode key pressed once cleanly → oMode 0→1 exactly 2+3+1 cycles after the raw edge. A bounce of 1-cycle glitches before stability → no toggle.
- Play mode, save press, iRUN=1 → oSave_n low for 1 cycle. oNote goes 01,02,…,09,10,11,12 every 4 cycles, then 01 with oBar=1.
- Last note of bar 2 with SEQ_LOOP_EN undefined → IDLE with oNote=8'h12, oBar=2, oBusy=0. With the macro defined → oNote=01, oBar=0, oBusy stays 1.
- RUN with iRUN=0 for 10 cycles → oNote unchanged. Save pressed with oMode=0 → IDLE with the value frozen.
- Save and mode presses coincident with oMode=1 at a note-advance cycle → restart to 01/0, oMode=0, no advance applied.
